// File: rtl/guess_game_pkg.sv
// Shared types for the guess-the-number game: FSM states, display symbol codes,
// the symbol-to-segment decoder and a constant binary-to-BCD helper.
package guess_game_pkg;

    typedef enum logic [2:0] {
        ST_SET   = 3'd0,
        ST_GUESS = 3'd1,
        ST_HINT  = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Codes 0x00-0x0F are plain hex digits.
    localparam logic [4:0] SYM_BLANK = 5'h10;
    localparam logic [4:0] SYM_H     = 5'h11;
    localparam logic [4:0] SYM_I     = 5'h12;
    localparam logic [4:0] SYM_L     = 5'h13;
    localparam logic [4:0] SYM_O     = 5'h14;
    localparam logic [4:0] SYM_P     = 5'h15;
    localparam logic [4:0] SYM_DASH  = 5'h16;

    // Active-low segments packed as {g,f,e,d,c,b,a}.
    function automatic logic [6:0] sym_to_seg(input logic [4:0] sym);
        logic [6:0] s;
        case (sym)
            5'h00:    s = 7'h40;
            5'h01:    s = 7'h79;
            5'h02:    s = 7'h24;
            5'h03:    s = 7'h30;
            5'h04:    s = 7'h19;
            5'h05:    s = 7'h12;
            5'h06:    s = 7'h02;
            5'h07:    s = 7'h78;
            5'h08:    s = 7'h00;
            5'h09:    s = 7'h10;
            5'h0A:    s = 7'h08;
            5'h0B:    s = 7'h03;
            5'h0C:    s = 7'h46;
            5'h0D:    s = 7'h21;
            5'h0E:    s = 7'h06;
            5'h0F:    s = 7'h0E;
            SYM_H:    s = 7'h09;
            SYM_I:    s = 7'h79;
            SYM_L:    s = 7'h47;
            SYM_O:    s = 7'h40;
            SYM_P:    s = 7'h0C;
            SYM_DASH: s = 7'h3F;
            default:  s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] to_bcd32(input int unsigned value);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/guess_game_seg7_scan.sv
// Time-multiplexed 7-segment driver: one position per SCAN_DIV clocks, leftmost
// first. Outputs are registered so reset blanks the display immediately.
module seg7_scan
    import guess_game_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*DIGITS-1:0] symbols,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int POS_W = $clog2(DIGITS);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [POS_W-1:0] POS_LEFT = POS_W'(DIGITS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = 1;

    logic [DIV_W-1:0]  r_div;
    logic [POS_W-1:0]  r_pos;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic [4:0]        w_sym;
    logic [DIGITS-1:0] w_an;

    always_comb begin
        w_sym = SYM_BLANK;
        w_an  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_pos == POS_W'(i)) begin
                w_sym   = symbols[5*i +: 5];
                w_an[i] = 1'b0;
            end
        end
    end

    // seg and an are both taken from the same r_pos, so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_pos <= POS_LEFT;
            r_seg <= '1;
            r_an  <= '1;
        end else begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_pos <= (r_pos == '0) ? POS_LEFT : r_pos - POS_ONE;
            end else begin
                r_div <= r_div + DIV_ONE;
            end
            r_seg <= sym_to_seg(w_sym);
            r_an  <= w_an;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: rtl/guess_game_core.sv
// Guess-the-number game: enter a secret, then guesses; shows LO/HI hints,
// counts tries in BCD and blinks the LEDs on WIN or LOSE until reset.
module guess_game_core
    import guess_game_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 5000000,
    parameter int MAX_TRIES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          digit_val,
    input  logic [DIGITS-1:0]   digit_load,
    input  logic                commit,
    input  logic                peek,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          led,
    output logic [2:0]          phase,
    output logic [4*DIGITS-1:0] tries_bcd
);

    localparam int W       = 4 * DIGITS;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = 1;
    localparam logic [DIGITS-1:0]  LOAD_ONE   = 1;
    localparam logic [31:0]        MAX_BCD32  = to_bcd32(MAX_TRIES);
    localparam logic [W-1:0]       MAX_BCD    = MAX_BCD32[W-1:0];

    state_t              r_state, w_next;
    logic                r_commit_s1, r_commit_s2, r_commit_d;
    logic                w_commit_edge, w_load_ok, w_load_en, w_lock, w_submit;
    logic [W-1:0]        r_entry, r_secret, r_guess, r_tries, w_tries_inc;
    logic                r_cmp_valid, r_cmp_eq, r_cmp_lt, r_cmp_limit;
    logic                r_prompt, r_blink;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic [7:0]          r_led, w_led;
    logic [5*DIGITS-1:0] w_syms;

    function automatic logic [5*DIGITS-1:0] hex_syms(input logic [W-1:0] v);
        logic [5*DIGITS-1:0] s;
        for (int i = 0; i < DIGITS; i++) s[5*i +: 5] = {1'b0, v[4*i +: 4]};
        return s;
    endfunction

    assign w_commit_edge = r_commit_s2 & ~r_commit_d;
    assign w_load_ok     = (digit_load != '0) && ((digit_load & (digit_load - LOAD_ONE)) == '0);
    assign w_load_en     = w_load_ok && (r_state == ST_SET || r_state == ST_GUESS || r_state == ST_HINT);
    assign w_lock        = w_commit_edge && (r_state == ST_SET);
    assign w_submit      = w_commit_edge && (r_state == ST_GUESS || r_state == ST_HINT);

    // Saturating BCD increment: an all-nines count stays put.
    always_comb begin : tries_inc
        logic carry;
        logic all9;
        carry       = 1'b1;
        all9        = 1'b1;
        w_tries_inc = r_tries;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_tries[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (r_tries[4*i +: 4] == 4'd9) begin
                    w_tries_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_tries_inc[4*i +: 4] = r_tries[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (all9) w_tries_inc = r_tries;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_s1 <= 1'b0;
            r_commit_s2 <= 1'b0;
            r_commit_d  <= 1'b0;
        end else begin
            r_commit_s1 <= commit;
            r_commit_s2 <= r_commit_s1;
            r_commit_d  <= r_commit_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry     <= '0;
            r_secret    <= '0;
            r_guess     <= '0;
            r_tries     <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_eq    <= 1'b0;
            r_cmp_lt    <= 1'b0;
            r_cmp_limit <= 1'b0;
            r_prompt    <= 1'b0;
        end else begin
            if (w_lock) begin
                r_entry  <= '0;
                r_secret <= r_entry;
                r_prompt <= 1'b1;
            end else if (w_load_en) begin
                for (int i = 0; i < DIGITS; i++)
                    if (digit_load[i]) r_entry[4*i +: 4] <= digit_val;
                r_prompt <= 1'b0;
            end
            r_cmp_valid <= w_submit;
            if (w_submit) begin
                r_guess     <= r_entry;
                r_tries     <= w_tries_inc;
                r_cmp_eq    <= (r_entry == r_secret);
                r_cmp_lt    <= (r_entry < r_secret);
                r_cmp_limit <= (MAX_TRIES != 0) && (w_tries_inc == MAX_BCD);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_state == ST_WIN || r_state == ST_LOSE) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_ONE;
            end
        end else begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_SET;
        else     r_state <= w_next;
    end

    // GUESS holds for one cycle after a submit so the registered compare decides.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SET:   if (w_commit_edge) w_next = ST_GUESS;
            ST_GUESS: begin
                if (r_cmp_valid) begin
                    if (r_cmp_eq)         w_next = ST_WIN;
                    else if (r_cmp_limit) w_next = ST_LOSE;
                    else                  w_next = ST_HINT;
                end
            end
            ST_HINT:  if (w_load_ok || w_commit_edge) w_next = ST_GUESS;
            default:  w_next = r_state;
        endcase
    end

    always_comb begin : fsm_out
        logic lead;
        w_syms = {DIGITS{SYM_BLANK}};
        w_led  = 8'h00;
        lead   = 1'b1;
        case (r_state)
            ST_SET: begin
                w_led  = 8'h01;
                w_syms = hex_syms(r_entry);
            end
            ST_GUESS: begin
                w_led = 8'h02;
                if (peek) begin
                    w_syms = hex_syms(r_guess);
                end else if (r_prompt) begin
                    w_syms[5*(DIGITS-1) +: 5] = SYM_P;
                    w_syms[5*(DIGITS-2) +: 5] = 5'h02;
                end else begin
                    w_syms = hex_syms(r_entry);
                end
            end
            ST_HINT: begin
                w_led = 8'h04;
                w_syms[5*(DIGITS-1) +: 5] = r_cmp_lt ? SYM_L : SYM_H;
                w_syms[5*(DIGITS-2) +: 5] = r_cmp_lt ? SYM_O : SYM_I;
            end
            ST_WIN: begin
                w_led = {8{r_blink}};
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    if (!(lead && r_tries[4*i +: 4] == 4'd0 && i != 0)) begin
                        lead = 1'b0;
                        w_syms[5*i +: 5] = {1'b0, r_tries[4*i +: 4]};
                    end
                end
            end
            ST_LOSE: begin
                w_led  = {8{r_blink}};
                w_syms = hex_syms(r_secret);
            end
            default: w_led = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_led <= 8'h00;
        else     r_led <= w_led;
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .symbols (w_syms),
        .seg     (seg),
        .an      (an)
    );

    assign led       = r_led;
    assign phase     = r_state;
    assign tries_bcd = r_tries;

endmodule

// File: tb/tb_guess_game_core.sv
// Directed bench for guess_game_core: one unlimited-tries instance (a_*) and
// one MAX_TRIES=2 instance (b_*) sharing clock and reset.
module tb_guess_game_core;

    localparam logic [6:0] G_0  = 7'h40;
    localparam logic [6:0] G_1  = 7'h79;
    localparam logic [6:0] G_2  = 7'h24;
    localparam logic [6:0] G_3  = 7'h30;
    localparam logic [6:0] G_7  = 7'h78;
    localparam logic [6:0] G_9  = 7'h10;
    localparam logic [6:0] G_A  = 7'h08;
    localparam logic [6:0] G_C  = 7'h46;
    localparam logic [6:0] G_H  = 7'h09;
    localparam logic [6:0] G_I  = 7'h79;
    localparam logic [6:0] G_L  = 7'h47;
    localparam logic [6:0] G_O  = 7'h40;
    localparam logic [6:0] G_P  = 7'h0C;
    localparam logic [6:0] G_BL = 7'h7F;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0]  a_val = '0, b_val = '0;
    logic [3:0]  a_load = '0, b_load = '0;
    logic        a_commit = 1'b0, b_commit = 1'b0;
    logic        a_peek = 1'b0, b_peek = 1'b0;
    logic [6:0]  a_seg, b_seg;
    logic [3:0]  a_an, b_an;
    logic [7:0]  a_led, b_led;
    logic [2:0]  a_phase, b_phase;
    logic [15:0] a_tries, b_tries;

    int vectors = 0;
    int miscompares = 0;
    int t1, t2;
    logic [7:0] v1, v2, prev;

    always #5 clk = ~clk;

    guess_game_core #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16), .MAX_TRIES(0)) dut_a (
        .clk(clk), .rst(rst), .digit_val(a_val), .digit_load(a_load), .commit(a_commit),
        .peek(a_peek), .seg(a_seg), .an(a_an), .led(a_led), .phase(a_phase), .tries_bcd(a_tries)
    );

    guess_game_core #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16), .MAX_TRIES(2)) dut_b (
        .clk(clk), .rst(rst), .digit_val(b_val), .digit_load(b_load), .commit(b_commit),
        .peek(b_peek), .seg(b_seg), .an(b_an), .led(b_led), .phase(b_phase), .tries_bcd(b_tries)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_load(input int u, input logic [3:0] mask, input logic [3:0] val);
        @(posedge clk); #1;
        if (u == 0) begin a_val = val; a_load = mask; end
        else        begin b_val = val; b_load = mask; end
        @(posedge clk); #1;
        if (u == 0) a_load = '0;
        else        b_load = '0;
    endtask

    task automatic load_word(input int u, input logic [15:0] w);
        for (int p = 3; p >= 0; p--) drive_load(u, 4'(1 << p), w[4*p +: 4]);
    endtask

    task automatic pulse_commit(input int u, input int hold);
        @(posedge clk); #1;
        if (u == 0) a_commit = 1'b1;
        else        b_commit = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        if (u == 0) a_commit = 1'b0;
        else        b_commit = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Samples 40 cycles (2.5 scan frames); keeps the last glyph seen per position.
    task automatic check_display(input int u, input string tag, input logic [27:0] exp_v);
        logic [6:0] cap [4];
        logic       bad;
        logic [3:0] an_s;
        logic [6:0] seg_s;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) cap[k] = 7'h00;
        repeat (40) begin
            @(negedge clk);
            an_s  = (u == 0) ? a_an : b_an;
            seg_s = (u == 0) ? a_seg : b_seg;
            case (an_s)
                4'b0111: cap[3] = seg_s;
                4'b1011: cap[2] = seg_s;
                4'b1101: cap[1] = seg_s;
                4'b1110: cap[0] = seg_s;
                default: bad = 1'b1;
            endcase
        end
        check(tag, {3'b000, bad, cap[3], cap[2], cap[1], cap[0]}, {4'b0000, exp_v});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg", a_seg, 7'h7F);
        check("rst_an", a_an, 4'hF);
        check("rst_led", a_led, 8'h00);
        check("rst_phase", a_phase, 3'd0);
        check("rst_tries", a_tries, 16'h0000);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check_display(0, "set_zero", {G_0, G_0, G_0, G_0});
        check("set_led", a_led, 8'h01);
        load_word(0, 16'h3A7C);
        check_display(0, "set_buf", {G_3, G_A, G_7, G_C});
        pulse_commit(0, 5);
        check("lock_phase", a_phase, 3'd1);
        check("guess_led", a_led, 8'h02);
        check_display(0, "prompt", {G_P, G_2, G_BL, G_BL});

        load_word(0, 16'h1000);
        check_display(0, "guess_buf", {G_1, G_0, G_0, G_0});
        pulse_commit(0, 5);
        check("lo_phase", a_phase, 3'd2);
        check("lo_tries", a_tries, 16'h0001);
        check("hint_led", a_led, 8'h04);
        check_display(0, "lo_disp", {G_L, G_O, G_BL, G_BL});

        load_word(0, 16'h9000);
        check("hint_to_guess", a_phase, 3'd1);
        @(posedge clk); #1 a_peek = 1'b1;
        check_display(0, "peek", {G_1, G_0, G_0, G_0});
        a_peek = 1'b0;
        check_display(0, "no_peek", {G_9, G_0, G_0, G_0});
        pulse_commit(0, 5);
        check("hi_phase", a_phase, 3'd2);
        check("hi_tries", a_tries, 16'h0002);
        check_display(0, "hi_disp", {G_H, G_I, G_BL, G_BL});

        load_word(0, 16'h3A7C);
        pulse_commit(0, 5);
        check("win_phase", a_phase, 3'd3);
        check("win_tries", a_tries, 16'h0003);
        check_display(0, "win_disp", {G_BL, G_BL, G_BL, G_3});

        t1 = -1; t2 = -1; v1 = '0; v2 = '0;
        @(negedge clk);
        prev = a_led;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a_led !== prev) begin
                if (t1 < 0) begin t1 = k; v1 = a_led; end
                else if (t2 < 0) begin t2 = k; v2 = a_led; end
                prev = a_led;
            end
        end
        check("blink_period", t2 - t1, 16);
        check("blink_toggle", v1 ^ v2, 8'hFF);
        check("blink_all_bits", (v1 == 8'h00 || v1 == 8'hFF), 1);

        pulse_commit(0, 5);
        load_word(0, 16'h1111);
        check("win_sticky_phase", a_phase, 3'd3);
        check("win_sticky_tries", a_tries, 16'h0003);
        check_display(0, "win_sticky_disp", {G_BL, G_BL, G_BL, G_3});

        load_word(1, 16'h3A7C);
        pulse_commit(1, 5);
        check("b_lock_phase", b_phase, 3'd1);
        load_word(1, 16'h1000);
        drive_load(1, 4'b0110, 4'h5);
        check_display(1, "b_multihot", {G_1, G_0, G_0, G_0});
        pulse_commit(1, 50);
        check("b_hold_tries", b_tries, 16'h0001);
        check("b_hold_phase", b_phase, 3'd2);
        pulse_commit(1, 5);
        check("b_lose_phase", b_phase, 3'd4);
        check("b_lose_tries", b_tries, 16'h0002);
        check_display(1, "b_lose_disp", {G_3, G_A, G_7, G_C});
        pulse_commit(1, 5);
        check("b_lose_sticky", b_phase, 3'd4);
        check("b_lose_sticky_tries", b_tries, 16'h0002);

        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        load_word(0, 16'h1234);
        pulse_commit(0, 5);
        load_word(0, 16'h0001);
        pulse_commit(0, 5);
        check("re_phase", a_phase, 3'd2);
        check("re_tries", a_tries, 16'h0001);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_seg", a_seg, 7'h7F);
        check("async_an", a_an, 4'hF);
        check("async_phase", a_phase, 3'd0);
        check("async_tries", a_tries, 16'h0000);
        check("async_led", a_led, 8'h00);
        check("async_b_phase", b_phase, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("first_slot", a_an, 4'b0111);
        repeat (4) @(negedge clk);
        check("second_slot", a_an, 4'b1011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
